// File: rtl/pair_detect_window.sv
// pair_detect_window: pipelined popcount threshold detector with debounce,
// a run-length FSM and a saturating count of detection events.
module pair_detect_window #(
  parameter int p_nbits  = 3,
  parameter int p_thresh = 2,
  parameter int p_hold   = 1,
  parameter int p_invert = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_val,
  input  logic [p_nbits-1:0]             in,
  input  logic                           clear,
  output logic [$clog2(p_nbits+1)-1:0]   count,
  output logic                           det_val,
  output logic                           det,
  output logic [7:0]                     event_cnt
);

  localparam int CW = $clog2(p_nbits + 1);
  localparam int RW = $clog2(p_hold + 1);
  localparam logic [CW-1:0] THR  = CW'(p_thresh);
  localparam logic [RW-1:0] HOLD = RW'(p_hold);
  localparam logic          INV  = (p_invert != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    DETECT = 2'd2
  } state_t;

  logic [CW-1:0] count_q, count_d;
  logic          v1_q;
  logic [RW-1:0] run_q, run_d;
  logic          det_q, det_d;
  logic          det_val_q;
  logic [7:0]    event_q;
  state_t        state_q;
  logic          match;
  logic          rise;

  // Stage 1 population count of the incoming sample.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < p_nbits; i++) begin
      count_d = count_d + CW'(in[i]);
    end
  end

  // Stage 1 registers: popcount is only refreshed by valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= in_val;
      if (in_val) begin
        count_q <= count_d;
      end
    end
  end

  // Stage 2 next-state: saturating run length and the debounced level.
  always_comb begin
    match = (count_q >= THR) ^ INV;
    run_d = run_q;
    if (v1_q) begin
      if (!match) begin
        run_d = '0;
      end else if (run_q != HOLD) begin
        run_d = run_q + RW'(1);
      end
    end
    det_d = (run_d == HOLD);
    rise  = det_d & ~det_q;
  end

  // Stage 2 FSM with registered outputs; clear wins over any same-cycle rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= '0;
      det_q     <= 1'b0;
      det_val_q <= 1'b0;
      event_q   <= '0;
      state_q   <= IDLE;
    end else begin
      det_val_q <= v1_q;
      if (clear) begin
        run_q   <= '0;
        det_q   <= 1'b0;
        event_q <= '0;
        state_q <= IDLE;
      end else begin
        run_q <= run_d;
        det_q <= det_d;
        if (rise && event_q != 8'hFF) begin
          event_q <= event_q + 8'd1;
        end
        case (state_q)
          IDLE: begin
            if (run_d == HOLD)    state_q <= DETECT;
            else if (run_d != '0) state_q <= ARM;
          end
          ARM: begin
            if (run_d == '0)        state_q <= IDLE;
            else if (run_d == HOLD) state_q <= DETECT;
          end
          DETECT: begin
            if (run_d == '0) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign count     = count_q;
  assign det_val   = det_val_q;
  assign det       = det_q;
  assign event_cnt = event_q;

endmodule

// File: tb/tb_pair_detect_window.sv
// Directed self-checking bench for pair_detect_window.
// Inst A: hold=1; inst B: hold=2; inst C: hold=1, inverted. Inputs are shared.
module tb_pair_detect_window;

  logic       clk = 1'b0;
  logic       rst, in_val, clear;
  logic [2:0] in;

  logic [1:0] cA, cB, cC;
  logic       dvA, dvB, dvC;
  logic       dA, dB, dC;
  logic [7:0] eA, eB, eC;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pair_detect_window #(.p_nbits(3), .p_thresh(2), .p_hold(1), .p_invert(0)) u_a (
    .clk(clk), .rst(rst), .in_val(in_val), .in(in), .clear(clear),
    .count(cA), .det_val(dvA), .det(dA), .event_cnt(eA));

  pair_detect_window #(.p_nbits(3), .p_thresh(2), .p_hold(2), .p_invert(0)) u_b (
    .clk(clk), .rst(rst), .in_val(in_val), .in(in), .clear(clear),
    .count(cB), .det_val(dvB), .det(dB), .event_cnt(eB));

  pair_detect_window #(.p_nbits(3), .p_thresh(2), .p_hold(1), .p_invert(1)) u_c (
    .clk(clk), .rst(rst), .in_val(in_val), .in(in), .clear(clear),
    .count(cC), .det_val(dvC), .det(dC), .event_cnt(eC));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_val = 1'b0; in = 3'b000; clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cA, dvA, dA, eA} !== 12'd0) begin
      bad++; $display("FAIL reset_A got=%h exp=0", {cA, dvA, dA, eA});
    end
    total++;
    if ({cB, dvB, dB, eB} !== 12'd0) begin
      bad++; $display("FAIL reset_B got=%h exp=0", {cB, dvB, dB, eB});
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] pc [8]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic       exd [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      in = 3'(v); in_val = 1'b1;
      @(negedge clk);
      in_val = 1'b0;
      total++;
      if (cA !== pc[v]) begin
        bad++; $display("FAIL tt_count in=%0d got=%0d exp=%0d", v, cA, pc[v]);
      end
      @(negedge clk);
      total++;
      if (dA !== exd[v]) begin
        bad++; $display("FAIL tt_det in=%0d got=%b exp=%b", v, dA, exd[v]);
      end
      total++;
      if (dvA !== 1'b1) begin
        bad++; $display("FAIL tt_det_val in=%0d got=%b exp=1", v, dvA);
      end
    end
  endtask

  task automatic test_debounce();
    do_reset();
    in = 3'b011; in_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in = 3'b001;
    total++;
    if (dB !== 1'b0) begin bad++; $display("FAIL deb_n2 got=%b exp=0", dB); end
    @(negedge clk);
    in_val = 1'b0;
    total++;
    if (dB !== 1'b1) begin bad++; $display("FAIL deb_n3 got=%b exp=1", dB); end
    total++;
    if (eB !== 8'd1) begin bad++; $display("FAIL deb_evt got=%0d exp=1", eB); end
    @(negedge clk);
    total++;
    if (dB !== 1'b0) begin bad++; $display("FAIL deb_drop got=%b exp=0", dB); end
    total++;
    if (eB !== 8'd1) begin bad++; $display("FAIL deb_evt2 got=%0d exp=1", eB); end
  endtask

  task automatic test_gaps();
    do_reset();
    in = 3'b011; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (dB !== 1'b0) begin bad++; $display("FAIL gap_hold%0d got=%b exp=0", i, dB); end
    end
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    @(negedge clk);
    total++;
    if (dB !== 1'b1) begin bad++; $display("FAIL gap_det got=%b exp=1", dB); end
    total++;
    if (eB !== 8'd1) begin bad++; $display("FAIL gap_evt got=%0d exp=1", eB); end
    repeat (2) @(negedge clk);
    total++;
    if (dB !== 1'b1) begin bad++; $display("FAIL gap_held got=%b exp=1", dB); end
  endtask

  task automatic test_invert();
    logic [2:0] vin [4] = '{3'b001, 3'b011, 3'b000, 3'b111};
    logic       vex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in = vin[k]; in_val = 1'b1;
      @(negedge clk);
      in_val = 1'b0;
      @(negedge clk);
      total++;
      if (dC !== vex[k]) begin
        bad++; $display("FAIL inv_det in=%b got=%b exp=%b", vin[k], dC, vex[k]);
      end
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in = 3'b110; in_val = 1'b1;
      @(negedge clk);
      in = 3'b000;
      @(negedge clk);
    end
    in_val = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (eA !== 8'd5) begin bad++; $display("FAIL sat_5 got=%0d exp=5", eA); end
    for (int i = 0; i < 295; i++) begin
      in = 3'b110; in_val = 1'b1;
      @(negedge clk);
      in = 3'b000;
      @(negedge clk);
    end
    in_val = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (eA !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", eA); end
    // clear coincides with the edge where det would rise
    in = 3'b110; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (eA !== 8'd0) begin bad++; $display("FAIL clr_evt got=%0d exp=0", eA); end
    total++;
    if (dA !== 1'b0) begin bad++; $display("FAIL clr_det got=%b exp=0", dA); end
    total++;
    if (cA !== 2'd2) begin bad++; $display("FAIL clr_count got=%0d exp=2", cA); end
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    @(negedge clk);
    total++;
    if (eA !== 8'd1) begin bad++; $display("FAIL clr_after got=%0d exp=1", eA); end
  endtask

  task automatic test_rst_mid_arm();
    do_reset();
    in = 3'b111; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    @(negedge clk);
    total++;
    if (dB !== 1'b0) begin bad++; $display("FAIL arm_det got=%b exp=0", dB); end
    rst = 1'b1; in_val = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_val = 1'b0;
    total++;
    if ({cB, dvB, dB, eB} !== 12'd0) begin
      bad++; $display("FAIL arm_rst got=%h exp=0", {cB, dvB, dB, eB});
    end
    repeat (2) @(negedge clk);
    total++;
    if ({cB, dvB, dB} !== 4'd0) begin
      bad++; $display("FAIL arm_discard got=%h exp=0", {cB, dvB, dB});
    end
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dB !== 1'b0) begin bad++; $display("FAIL arm_fresh got=%b exp=0", dB); end
    total++;
    if (cB !== 2'd3) begin bad++; $display("FAIL arm_count got=%0d exp=3", cB); end
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; in = 3'b000; clear = 1'b0;
    test_reset();
    test_truth_table();
    test_debounce();
    test_gaps();
    test_invert();
    test_saturation_clear();
    test_rst_mid_arm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
